apb_mem_slave: RTL

Parametrised APB slave fronting an on-chip word memory. It is the APB completer used behind the lab interconnect for scratch/register storage. Versus the first-generation slave it adds:
- generic data width and depth
- byte-lane write strobes
- programmable wait states
- a registered, cycle-exact APB state machine
- PSLVERR on out-of-range accesses

---
 rtl/apb_mem_slave_if.sv | 41 ++++
 rtl/apb_mem_slave.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave_if.sv
// ---------------------------------------------------------------------------
// apb_mem_slave_if
// APB bus bundle between a requester and the apb_mem_slave completer.
//
// Signals:
//   psel     requester -> completer  slave select
//   penable  requester -> completer  access-phase indicator
//   pwrite   requester -> completer  1 = write, 0 = read
//   paddr    requester -> completer  byte address, ADDR_W bits
//   pwdata   requester -> completer  write data, DATA_W bits
//   pstrb    requester -> completer  write byte-lane enables, DATA_W/8 bits
//   pready   completer -> requester  transfer completes this cycle
//   pslverr  completer -> requester  error response, valid with pready
//   prdata   completer -> requester  read data, valid with pready on reads
// ---------------------------------------------------------------------------
interface apb_mem_slave_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_W-1:0]     prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, pslverr, prdata
  );

endinterface

// File: rtl/apb_mem_slave.sv
// ---------------------------------------------------------------------------
// apb_mem_slave
// APB completer fronting an on-chip word memory of DEPTH x DATA_W bits.
// Supports byte-lane write strobes, WAIT_STATES extra access-phase cycles,
// and an error response for word indices beyond DEPTH.
//
// Parameters:
//   ADDR_W       byte address width
//   DATA_W       data width (8, 16 or 32)
//   DEPTH        number of words
//   WAIT_STATES  extra access-phase cycles before pready (0..15)
//
// Ports:
//   i_clk   system clock, rising edge
//   i_rst   synchronous active-high reset (FSM and outputs only)
//   apb     APB bus, slave modport of apb_mem_slave_if
// ---------------------------------------------------------------------------
module apb_mem_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  apb_mem_slave_if.slave apb
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_strb;
  logic              r_pready;
  logic              r_pslverr;
  logic [DATA_W-1:0] r_prdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_setup;
  logic              w_curWrite;
  logic [ADDR_W-1:0] w_curAddr;
  logic [ADDR_W-1:0] w_wordIdx;
  logic [MEM_AW-1:0] w_memIdx;
  logic              w_err;
  logic [DATA_W-1:0] w_rdNext;
  logic              w_complete;
  logic              w_commit;
  logic [3:0]        w_cntNext;

  assign w_setup = apb.psel && !apb.penable;

  // With zero wait states READY is entered on the setup edge itself, so the
  // error check and memory read must look at the live bus instead of the
  // latch that is only being loaded on that same edge.
  assign w_curWrite = (r_state == ST_IDLE) ? apb.pwrite : r_write;
  assign w_curAddr  = (r_state == ST_IDLE) ? apb.paddr  : r_addr;

  assign w_wordIdx = w_curAddr >> OFF_W;
  assign w_memIdx  = w_wordIdx[MEM_AW-1:0];
  assign w_err     = (32'(w_wordIdx) >= 32'(DEPTH));
  assign w_rdNext  = (w_err || w_curWrite) ? '0 : r_mem[w_memIdx];

  assign w_complete = (r_state == ST_READY) && apb.psel && apb.penable;
  assign w_commit   = w_complete && r_write && !w_err && !i_rst;
  assign w_cntNext  = r_cnt + 4'd1;

  assign apb.pready  = r_pready;
  assign apb.pslverr = r_pslverr;
  assign apb.prdata  = r_prdata;

  // Transfer state machine; the response outputs are loaded on entry to
  // READY and cleared whenever READY is left.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_setup) begin
            r_write <= apb.pwrite;
            r_addr  <= apb.paddr;
            r_wdata <= apb.pwdata;
            r_strb  <= apb.pstrb;
            r_cnt   <= '0;
            if (WAIT_STATES == 0) begin
              r_state   <= ST_READY;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_rdNext;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!apb.psel) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= w_cntNext;
            if (w_cntNext == WAIT_LAST) begin
              r_state   <= ST_READY;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_rdNext;
            end
          end
        end
        ST_READY: begin
          // Hold the response while the requester keeps PSEL without
          // PENABLE; completion or deselect both end the transfer.
          if (!apb.psel || apb.penable) begin
            r_state   <= ST_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
        end
      endcase
    end
  end

  // Word memory; not reset. Only strobed lanes of an in-range write are
  // updated, and a write coinciding with reset is dropped.
  always_ff @(posedge i_clk) begin
    if (w_commit) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (r_strb[i]) begin
          r_mem[w_memIdx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
